// File: rtl/scr_tail_pad.sv
// scr_tail_pad: 802.11a DATA-field framing and scrambling stage.
// Each frame is emitted as 16 scrambled SERVICE zeros, 8*LEN scrambled PSDU
// bits, 6 zero tail bits, then scrambled pad bits that fill out the last
// OFDM symbol (N_DBPS selected by the RATE code).
// Build option: define SCR_SEED_PORT_EN to add a seed_i input port that
// supplies the scrambler seed at start. Without it, the SEED parameter
// supplies the seed.
//
// Handshake: di_vld_i is a valid-only strobe with no back-pressure. The
// block accepts a di_i bit on every clock edge where di_vld_i is high and
// the FSM is in DATA, up to 8*LEN bits. It ignores di_vld_i at all other
// times. do_vld_o marks each output bit; the encoder must always take it.
module scr_tail_pad #(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [11:0] di_len_i,
    input  logic [3:0]  di_type_i,
    input  logic        di_i,
    input  logic        di_vld_i,
`ifdef SCR_SEED_PORT_EN
    input  logic [6:0]  seed_i,
`endif
    output logic        rd_en_o,
    output logic        do_o,
    output logic        do_vld_o,
    output logic        do_last_o,
    output logic        busy_o,
    output logic        rate_err_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SERVICE = 3'd1,
        S_DATA    = 3'd2,
        S_TAIL    = 3'd3,
        S_PAD     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]  sym_cnt_q, sym_cnt_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [11:0] len_q, len_d;
    logic [7:0]  ndbps_q, ndbps_d;
    logic        rd_en_q, rd_en_d;
    logic        do_q, do_d;
    logic        do_vld_q, do_vld_d;
    logic        do_last_q, do_last_d;
    logic        busy_q, busy_d;
    logic        rate_err_q, rate_err_d;

    logic [7:0]  ndbps_in;
    logic        start_ok;
    logic        accept;
    logic        emit;
    logic        fb;
    logic        sym_last;
    logic [14:0] data_last;
    logic [6:0]  seed_eff;

    // RATE code to data bits per OFDM symbol. A return value of zero means
    // the code is not a valid RATE.
    function automatic logic [7:0] ndbps_lut(input logic [3:0] code);
        logic [7:0] r;
        case (code)
            4'b1101: r = 8'd24;
            4'b1111: r = 8'd36;
            4'b0101: r = 8'd48;
            4'b0111: r = 8'd72;
            4'b1001: r = 8'd96;
            4'b1011: r = 8'd144;
            4'b0001: r = 8'd192;
            4'b0011: r = 8'd216;
            default: r = 8'd0;
        endcase
        return r;
    endfunction

`ifdef SCR_SEED_PORT_EN
    assign seed_eff = (seed_i == 7'd0) ? 7'h7F : seed_i;
`else
    assign seed_eff = (SEED == 7'd0) ? 7'h7F : SEED;
`endif

    // While busy_q is high (which includes the do_last cycle), start is
    // ignored even though the state has already returned to IDLE.
    assign ndbps_in  = ndbps_lut(di_type_i);
    assign start_ok  = (state_q == S_IDLE) && start_i && !busy_q;
    assign accept    = start_ok && (ndbps_in != 8'd0);
    assign fb        = lfsr_q[6] ^ lfsr_q[3];
    assign sym_last  = (sym_cnt_q == (ndbps_q - 8'd1));
    assign data_last = {len_q, 3'b000} - 15'd1;

    // State register and frame counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state logic. bit_cnt counts bits within the current phase.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_SERVICE;
                    bit_cnt_d = '0;
                end
            end
            S_SERVICE: begin
                if (bit_cnt_q == 15'd15) begin
                    bit_cnt_d = '0;
                    state_d   = (len_q == 12'd0) ? S_TAIL : S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 15'd1;
                end
            end
            S_DATA: begin
                if (di_vld_i) begin
                    if (bit_cnt_q == data_last) begin
                        bit_cnt_d = '0;
                        state_d   = S_TAIL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 15'd1;
                    end
                end
            end
            S_TAIL: begin
                if (bit_cnt_q == 15'd5) begin
                    bit_cnt_d = '0;
                    state_d   = sym_last ? S_IDLE : S_PAD;
                end else begin
                    bit_cnt_d = bit_cnt_q + 15'd1;
                end
            end
            S_PAD: begin
                if (sym_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Output and datapath next values. The LFSR and the symbol counter
    // advance once per emitted bit, and tail bits count as emitted bits.
    always_comb begin
        emit       = 1'b0;
        do_d       = 1'b0;
        lfsr_d     = lfsr_q;
        sym_cnt_d  = sym_cnt_q;
        len_d      = len_q;
        ndbps_d    = ndbps_q;
        rd_en_d    = 1'b0;
        do_last_d  = 1'b0;
        rate_err_d = start_ok && (ndbps_in == 8'd0);
        case (state_q)
            S_SERVICE: begin
                emit    = 1'b1;
                do_d    = fb;
                rd_en_d = (bit_cnt_q == 15'd15) && (len_q != 12'd0);
            end
            S_DATA: begin
                emit = di_vld_i;
                do_d = di_vld_i & (di_i ^ fb);
            end
            S_TAIL: begin
                emit      = 1'b1;
                do_d      = 1'b0;
                do_last_d = (bit_cnt_q == 15'd5) && sym_last;
            end
            S_PAD: begin
                emit      = 1'b1;
                do_d      = fb;
                do_last_d = sym_last;
            end
            default: begin
                emit = 1'b0;
            end
        endcase
        if (accept) begin
            lfsr_d    = seed_eff;
            sym_cnt_d = '0;
            len_d     = di_len_i;
            ndbps_d   = ndbps_in;
        end else if (emit) begin
            lfsr_d    = {lfsr_q[5:0], fb};
            sym_cnt_d = sym_last ? 8'd0 : sym_cnt_q + 8'd1;
        end
        do_vld_d = emit;
        busy_d   = (state_d != S_IDLE) || do_last_d;
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q     <= seed_eff;
            sym_cnt_q  <= '0;
            len_q      <= '0;
            ndbps_q    <= '0;
            rd_en_q    <= 1'b0;
            do_q       <= 1'b0;
            do_vld_q   <= 1'b0;
            do_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            rate_err_q <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            sym_cnt_q  <= sym_cnt_d;
            len_q      <= len_d;
            ndbps_q    <= ndbps_d;
            rd_en_q    <= rd_en_d;
            do_q       <= do_d;
            do_vld_q   <= do_vld_d;
            do_last_q  <= do_last_d;
            busy_q     <= busy_d;
            rate_err_q <= rate_err_d;
        end
    end

    assign rd_en_o    = rd_en_q;
    assign do_o       = do_q;
    assign do_vld_o   = do_vld_q;
    assign do_last_o  = do_last_q;
    assign busy_o     = busy_q;
    assign rate_err_o = rate_err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_scr_tail_pad.sv
// Testbench for scr_tail_pad: reference scrambler model feeding an
// expected-bit queue, frame driver task, and a do_vld-driven monitor.
module tb_scr_tail_pad;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] di_len;
    logic [3:0]  di_type;
    logic        di;
    logic        di_vld;
`ifdef SCR_SEED_PORT_EN
    logic [6:0]  seed;
`endif
    logic        rd_en_o;
    logic        do_o;
    logic        do_vld_o;
    logic        do_last_o;
    logic        busy_o;
    logic        rate_err_o;
    logic [2:0]  state_o;

    scr_tail_pad dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .di_len_i   (di_len),
        .di_type_i  (di_type),
        .di_i       (di),
        .di_vld_i   (di_vld),
`ifdef SCR_SEED_PORT_EN
        .seed_i     (seed),
`endif
        .rd_en_o    (rd_en_o),
        .do_o       (do_o),
        .do_vld_o   (do_vld_o),
        .do_last_o  (do_last_o),
        .busy_o     (busy_o),
        .rate_err_o (rate_err_o),
        .state_o    (state_o)
    );

    // Clock
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         bits_seen = 0;
    int         rd_cnt = 0;
    logic       mon_en = 1'b1;
    logic [1:0] exp_q[$];          // {last, bit}
    logic       payload [0:1023];
    logic [6:0] model_seed = 7'h7F;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: every do_vld bit is popped and compared with {do_last, do}.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (rd_en_o) rd_cnt++;
            if (do_vld_o) begin
                bits_seen++;
                if (exp_q.size() == 0) begin
                    check("extra_bit", 32'd1, 32'd0);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    check("do_bit", {30'd0, do_last_o, do_o}, {30'd0, e});
                end
            end
        end
    end

    function automatic int ndbps_of(input logic [3:0] t);
        case (t)
            4'b1101: return 24;
            4'b1111: return 36;
            4'b0101: return 48;
            4'b0111: return 72;
            4'b1001: return 96;
            4'b1011: return 144;
            4'b0001: return 192;
            4'b0011: return 216;
            default: return 0;
        endcase
    endfunction

    // Reference model: pushes the full expected frame.
    task automatic build_exp(input int len, input int nd, input logic [6:0] sd);
        logic [6:0] s;
        logic       f;
        logic       b;
        int         total;
        s = (sd == 7'd0) ? 7'h7F : sd;
        total = nd * ((22 + 8 * len + nd - 1) / nd);
        for (int k = 0; k < total; k++) begin
            f = s[6] ^ s[3];
            s = {s[5:0], f};
            if (k < 16)                b = f;
            else if (k < 16 + 8 * len) b = payload[k - 16] ^ f;
            else if (k < 22 + 8 * len) b = 1'b0;
            else                       b = f;
            exp_q.push_back({(k == total - 1), b});
        end
    endtask

    task automatic run_frame(input int len, input logic [3:0] typ, input int gap_after,
                             input int gap_len, input int exp_bits, input logic start_on_last);
        int   nd;
        int   c0;
        int   lat_exp;
        logic got;
        nd = ndbps_of(typ);
        build_exp(len, nd, model_seed);
        bits_seen = 0;
        rd_cnt = 0;
        @(posedge clk) #1;
        start = 1'b1; di_len = len[11:0]; di_type = typ;
        @(posedge clk) #1;
        start = 1'b0;
        c0 = cyc;
        @(negedge clk);
        check("busy_on_accept", {31'd0, busy_o}, 32'd1);
        if (len > 0) begin
            got = 1'b0;
            for (int i = 1; i < 40 && !got; i++) begin
                @(negedge clk);
                if (i == 3) start = 1'b1;      // start while busy must be ignored
                if (i == 4) start = 1'b0;
                if (rd_en_o) begin
                    got = 1'b1;
                    check("rd_en_cycle", cyc - c0, 32'd16);
                end
            end
            start = 1'b0;
            if (!got) check("rd_en_timeout", 32'd0, 32'd1);
            for (int i = 0; i < 8 * len; i++) begin
                if (i == gap_after) begin
                    repeat (gap_len) begin
                        @(posedge clk) #1;
                        di_vld = 1'b0;
                    end
                end
                @(posedge clk) #1;
                di = payload[i]; di_vld = 1'b1;
            end
            @(posedge clk) #1;
            di_vld = 1'b0; di = 1'b0;
        end
        lat_exp = exp_bits + ((len > 0) ? 1 + gap_len : 0);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (do_last_o) begin
                got = 1'b1;
                check("do_last_cycle", cyc - c0, lat_exp);
                if (start_on_last) start = 1'b1;
            end
        end
        if (!got) check("do_last_timeout", 32'd0, 32'd1);
        @(posedge clk) #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_last", {31'd0, busy_o}, 32'd0);
        check("bits_seen", bits_seen, exp_bits);
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("rd_en_count", rd_cnt, (len > 0) ? 32'd1 : 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Clock/reset
        rst = 1'b1; start = 1'b0; di_len = '0; di_type = '0; di = 1'b0; di_vld = 1'b0;
`ifdef SCR_SEED_PORT_EN
        seed = 7'h7F;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {26'd0, rd_en_o, do_o, do_vld_o, do_last_o, busy_o, rate_err_o}, 32'd0);
        check("reset_state", {29'd0, state_o}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame A: LEN=0 at 24 bits, start during do_last ignored
        for (int i = 0; i < 1024; i++) payload[i] = 1'b0;
        run_frame(0, 4'b1101, 0, 0, 24, 1'b1);

        // Frame B: LEN=1, all-ones payload, 2-cycle gap after bit 3
        for (int i = 0; i < 8; i++) payload[i] = 1'b1;
        run_frame(1, 4'b1101, 3, 2, 48, 1'b0);

        // Frame C: LEN=100 at 216, random payload and random gap
        for (int i = 0; i < 1024; i++) payload[i] = 1'($urandom_range(0, 1));
        run_frame(100, 4'b0011, $urandom_range(1, 799), $urandom_range(0, 3), 864, 1'b0);

        // Frame D: LEN=25 at 72, closing bit is a pad bit
        for (int i = 0; i < 1024; i++) payload[i] = 1'($urandom_range(0, 1));
        run_frame(25, 4'b0111, 1000, 0, 288, 1'b0);

        // Invalid RATE code
        @(posedge clk) #1;
        start = 1'b1; di_type = 4'b0000; di_len = 12'd5;
        @(posedge clk) #1;
        start = 1'b0;
        @(negedge clk);
        check("rate_err_pulse", {31'd0, rate_err_o}, 32'd1);
        check("rate_err_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        check("rate_err_clear", {31'd0, rate_err_o}, 32'd0);
        check("rate_err_state", {29'd0, state_o}, 32'd0);
        repeat (5) @(negedge clk);

        // Reset during DATA abandons the frame
        mon_en = 1'b0;
        @(posedge clk) #1;
        start = 1'b1; di_type = 4'b1101; di_len = 12'd10;
        @(posedge clk) #1;
        start = 1'b0;
        repeat (25) begin
            @(posedge clk) #1;
            di = 1'($urandom_range(0, 1)); di_vld = 1'b1;
        end
        @(negedge clk);
        check("pre_rst_state", {29'd0, state_o}, 32'd2);
        @(posedge clk) #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outs", {26'd0, rd_en_o, do_o, do_vld_o, do_last_o, busy_o, rate_err_o}, 32'd0);
        check("rst_mid_state", {29'd0, state_o}, 32'd0);
        @(posedge clk) #1;
        rst = 1'b0; di_vld = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Frame E after reset: LEN=3 at 96
        for (int i = 0; i < 1024; i++) payload[i] = 1'($urandom_range(0, 1));
        run_frame(3, 4'b1001, 5, 1, 96, 1'b0);

`ifdef SCR_SEED_PORT_EN
        seed = 7'h5D; model_seed = 7'h5D;
        run_frame(0, 4'b1101, 0, 0, 24, 1'b0);
        seed = 7'h00; model_seed = 7'h7F;
        run_frame(0, 4'b1101, 0, 0, 24, 1'b0);
`endif

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
